// File: rtl/score_display_mux.sv
// Four-digit multiplexed seven-segment driver for the Nim score counter.
// Latches one score snapshot per scan frame and supports zero-blanking and per-player flashing.
module score_display_mux #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 125,
  parameter bit LZB          = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] left_score_high,
  input  logic [3:0] left_score_low,
  input  logic [3:0] right_score_high,
  input  logic [3:0] right_score_low,
  input  logic       blink_l,
  input  logic       blink_r,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       digit_idx;
  logic [FRM_W-1:0] frame_cnt;
  logic             blink_phase;
  logic             started;
  logic [3:0]       snap_lh, snap_ll, snap_rh, snap_rl;

  logic             tc;
  logic             frame_wrap;
  logic [3:0]       cur_lh, cur_ll, cur_rh, cur_rl;
  logic [3:0]       digit_val;
  logic             is_left, is_high;
  logic             blank;
  logic [3:0]       an_next;
  logic [6:0]       seg_next;
  logic             dp_next;

  assign tc         = (div_cnt == DIV_LAST);
  assign frame_wrap = tc && (digit_idx == 2'd3);

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt   <= '0;
      digit_idx <= 2'd0;
    end else begin
      div_cnt <= tc ? '0 : div_cnt + 1'b1;
      if (tc) digit_idx <= digit_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_wrap) begin
      if (frame_cnt == FRM_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Scores are captured only at frame boundaries so a frame never mixes old and new digits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started <= 1'b0;
      snap_lh <= 4'd0;
      snap_ll <= 4'd0;
      snap_rh <= 4'd0;
      snap_rl <= 4'd0;
    end else begin
      started <= 1'b1;
      if (!started || frame_wrap) begin
        snap_lh <= left_score_high;
        snap_ll <= left_score_low;
        snap_rh <= right_score_high;
        snap_rl <= right_score_low;
      end
    end
  end

  // On the first clock after reset the snapshot is still empty, so decode straight from the inputs being captured.
  always_comb begin
    cur_lh = started ? snap_lh : left_score_high;
    cur_ll = started ? snap_ll : left_score_low;
    cur_rh = started ? snap_rh : right_score_high;
    cur_rl = started ? snap_rl : right_score_low;

    case (digit_idx)
      2'd0:    digit_val = cur_lh;
      2'd1:    digit_val = cur_ll;
      2'd2:    digit_val = cur_rh;
      default: digit_val = cur_rl;
    endcase

    is_left = ~digit_idx[1];
    is_high = ~digit_idx[0];
    blank   = (blink_phase && (is_left ? blink_l : blink_r))
            || (LZB && is_high && (digit_val == 4'd0));

    case (digit_idx)
      2'd0:    an_next = 4'b0111;
      2'd1:    an_next = 4'b1011;
      2'd2:    an_next = 4'b1101;
      default: an_next = 4'b1110;
    endcase
    if (blank) an_next = 4'b1111;

    seg_next = blank ? 7'b1111111 : seg_decode(digit_val);
    dp_next  = ~((digit_idx == 2'd1) && !blank);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule
